// File: rtl/cpu_mpu_multi.sv
// ---------------------------------------------------------------------------
// cpu_mpu_multi
// Memory protection unit for user-mode data accesses and instruction fetches.
// Each access is checked against NUM_REGIONS CSR-programmed descriptors, and a
// registered deny pulse is returned one cycle after the request. The first
// violation is held in sticky fault registers, and a saturating counter
// records how many violations have occurred.
//
// Ports
//   i_clock         system clock
//   i_reset_n       asynchronous active-low reset
//   i_supervisor    1 = supervisor mode (every access allowed)
//   i_cpud_request  data access request (one-cycle pulse)
//   i_cpud_write    1 = store, 0 = load
//   i_cpud_addr     data access address
//   i_cpui_request  instruction fetch request (one-cycle pulse)
//   i_cpui_addr     fetch address
//   i_csr_mpu       region descriptors, region i at [32*i+31 : 32*i]
//   i_fault_clear   clears fault valid/addr/cause/count
//   o_dmpu_deny     data access denied (cycle after request)
//   o_impu_deny     fetch denied (cycle after request)
//   o_fault_valid   sticky: a violation has been captured
//   o_fault_addr    address of the first captured violation
//   o_fault_cause   00 load, 01 store, 10 fetch
//   o_fault_count   saturating violation count since last clear
//
// Descriptor layout: [31:12] base, [10] X, [9] W, [8] R, [3:0] log2 size
// (0 = 4 KB ... 15 = 128 MB). Bits [11] and [7:4] are reserved.
// ---------------------------------------------------------------------------
module cpu_mpu_multi #(
    parameter int unsigned NUM_REGIONS = 8,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_supervisor,
    input  logic                      i_cpud_request,
    input  logic                      i_cpud_write,
    input  logic [31:0]               i_cpud_addr,
    input  logic                      i_cpui_request,
    input  logic [31:0]               i_cpui_addr,
    input  logic [NUM_REGIONS*32-1:0] i_csr_mpu,
    input  logic                      i_fault_clear,
    output logic                      o_dmpu_deny,
    output logic                      o_impu_deny,
    output logic                      o_fault_valid,
    output logic [31:0]               o_fault_addr,
    output logic [1:0]                o_fault_cause,
    output logic [COUNT_WIDTH-1:0]    o_fault_count
);

    localparam int unsigned PAGE_W = 20;
    localparam int unsigned CNT_EXT_W = COUNT_WIDTH + 1;

    localparam logic [1:0] CAUSE_LOAD  = 2'b00;
    localparam logic [1:0] CAUSE_STORE = 2'b01;
    localparam logic [1:0] CAUSE_FETCH = 2'b10;

    // Registered state
    logic                   r_dmpu_deny;
    logic                   r_impu_deny;
    logic                   r_fault_valid;
    logic [31:0]            r_fault_addr;
    logic [1:0]             r_fault_cause;
    logic [COUNT_WIDTH-1:0] r_fault_count;

    // Per-region permit vectors
    logic [NUM_REGIONS-1:0] w_d_permit;
    logic [NUM_REGIONS-1:0] w_i_permit;

    // Deny decision and next-state values for the fault registers
    logic                   w_d_deny;
    logic                   w_i_deny;
    logic [1:0]             w_num_deny;
    logic                   w_valid_base;
    logic                   w_valid_next;
    logic [31:0]            w_addr_next;
    logic [1:0]             w_cause_next;
    logic [COUNT_WIDTH-1:0] w_count_base;
    logic [CNT_EXT_W-1:0]   w_count_sum;
    logic [COUNT_WIDTH-1:0] w_count_next;

    // Per-region match: compare the page number above the size mask.
    genvar g;
    generate
        for (g = 0; g < NUM_REGIONS; g++) begin : g_region
            logic [PAGE_W-1:0] w_base;
            logic [PAGE_W-1:0] w_mask;
            logic [3:0]        w_size;
            logic              w_perm_r;
            logic              w_perm_w;
            logic              w_perm_x;
            logic              w_d_hit;
            logic              w_i_hit;
            logic              w_unused_rsvd;

            assign w_base   = i_csr_mpu[32*g+12 +: PAGE_W];
            assign w_size   = i_csr_mpu[32*g +: 4];
            assign w_perm_r = i_csr_mpu[32*g+8];
            assign w_perm_w = i_csr_mpu[32*g+9];
            assign w_perm_x = i_csr_mpu[32*g+10];

            // Reserved descriptor bits do not affect the decision.
            assign w_unused_rsvd = ^{i_csr_mpu[32*g+11], i_csr_mpu[32*g+4 +: 4]};

            // A 4-bit size code tops out at 15, so no clamp is needed.
            assign w_mask = {PAGE_W{1'b1}} << w_size;

            assign w_d_hit = ((i_cpud_addr[31:12] & w_mask) == (w_base & w_mask));
            assign w_i_hit = ((i_cpui_addr[31:12] & w_mask) == (w_base & w_mask));

            assign w_d_permit[g] = w_d_hit && (i_cpud_write ? w_perm_w : w_perm_r);
            assign w_i_permit[g] = w_i_hit && w_perm_x;
        end
    endgenerate

    // Overlapping regions are OR-combined, and supervisor mode bypasses the check.
    assign w_d_deny = i_cpud_request && !i_supervisor && !(|w_d_permit);
    assign w_i_deny = i_cpui_request && !i_supervisor && !(|w_i_permit);

    assign w_num_deny = {1'b0, w_d_deny} + {1'b0, w_i_deny};

    // Capture logic. A clear first zeroes the state, and any deny in the
    // same cycle is then applied to that zeroed state.
    always_comb begin
        w_valid_base = r_fault_valid;
        w_addr_next  = r_fault_addr;
        w_cause_next = r_fault_cause;

        if (i_fault_clear) begin
            w_valid_base = 1'b0;
            w_addr_next  = '0;
            w_cause_next = CAUSE_LOAD;
        end

        w_valid_next = w_valid_base;

        if (!w_valid_base && (w_d_deny || w_i_deny)) begin
            w_valid_next = 1'b1;
            // The data channel wins when both channels fault together.
            if (w_d_deny) begin
                w_addr_next  = i_cpud_addr;
                w_cause_next = i_cpud_write ? CAUSE_STORE : CAUSE_LOAD;
            end else begin
                w_addr_next  = i_cpui_addr;
                w_cause_next = CAUSE_FETCH;
            end
        end
    end

    // Saturating counter. The extra sum bit flags overflow past all-ones.
    always_comb begin
        w_count_base = i_fault_clear ? '0 : r_fault_count;
        w_count_sum  = {1'b0, w_count_base} + CNT_EXT_W'(w_num_deny);
        w_count_next = w_count_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}}
                                                : w_count_sum[COUNT_WIDTH-1:0];
    end

    // State registers. Reset discards any deny still pending.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dmpu_deny   <= 1'b0;
            r_impu_deny   <= 1'b0;
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_cause <= '0;
            r_fault_count <= '0;
        end else begin
            r_dmpu_deny   <= w_d_deny;
            r_impu_deny   <= w_i_deny;
            r_fault_valid <= w_valid_next;
            r_fault_addr  <= w_addr_next;
            r_fault_cause <= w_cause_next;
            r_fault_count <= w_count_next;
        end
    end

    assign o_dmpu_deny   = r_dmpu_deny;
    assign o_impu_deny   = r_impu_deny;
    assign o_fault_valid = r_fault_valid;
    assign o_fault_addr  = r_fault_addr;
    assign o_fault_cause = r_fault_cause;
    assign o_fault_count = r_fault_count;

endmodule

// File: tb/tb_cpu_mpu_multi.sv
// ---------------------------------------------------------------------------
// tb_cpu_mpu_multi
// Self-checking bench for cpu_mpu_multi (8 regions, 8-bit counter).
// Runs a table of directed single accesses, hand-written multi-cycle
// sequences, and randomized traffic. Every cycle is checked against a
// behavioural model that describes each region as a byte-address range.
// ---------------------------------------------------------------------------
module tb_cpu_mpu_multi;

    localparam int unsigned NR = 8;
    localparam int unsigned CW = 8;

    logic            clk;
    logic            rst_n;
    logic            sup;
    logic            dreq;
    logic            dwr;
    logic [31:0]     daddr;
    logic            ireq;
    logic [31:0]     iaddr;
    logic [NR*32-1:0] csr_bus;
    logic            fclr;
    logic            dmpu_deny;
    logic            impu_deny;
    logic            fault_valid;
    logic [31:0]     fault_addr;
    logic [1:0]      fault_cause;
    logic [CW-1:0]   fault_count;

    logic [31:0]     regs [NR];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_addr;
    logic [1:0]  m_cause;
    int          m_count;
    bit          m_d;
    bit          m_i;

    cpu_mpu_multi #(.NUM_REGIONS(NR), .COUNT_WIDTH(CW)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_supervisor   (sup),
        .i_cpud_request (dreq),
        .i_cpud_write   (dwr),
        .i_cpud_addr    (daddr),
        .i_cpui_request (ireq),
        .i_cpui_addr    (iaddr),
        .i_csr_mpu      (csr_bus),
        .i_fault_clear  (fclr),
        .o_dmpu_deny    (dmpu_deny),
        .o_impu_deny    (impu_deny),
        .o_fault_valid  (fault_valid),
        .o_fault_addr   (fault_addr),
        .o_fault_cause  (fault_cause),
        .o_fault_count  (fault_count)
    );

    always_comb begin
        for (int i = 0; i < NR; i++) csr_bus[32*i +: 32] = regs[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Region as a byte range: [aligned start, start + 4 KB << size)
    function automatic bit model_permit(input logic [31:0] addr, input int kind);
        logic [63:0] sz;
        logic [63:0] start;
        for (int r = 0; r < NR; r++) begin
            sz    = 64'h1000 << regs[r][3:0];
            start = {32'h0, regs[r][31:12], 12'h000} & ~(sz - 64'd1);
            if (regs[r][8+kind] && ({32'h0, addr} >= start) && ({32'h0, addr} < start + sz))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_addr = '0; m_cause = '0; m_count = 0; m_d = 0; m_i = 0;
    endtask

    // One clock: predict, advance, then compare all outputs.
    task automatic cycle();
        bit ed, ei;
        ed = dreq && !sup && !model_permit(daddr, dwr ? 1 : 0);
        ei = ireq && !sup && !model_permit(iaddr, 2);
        if (fclr) begin
            m_valid = 0; m_addr = '0; m_cause = '0; m_count = 0;
        end
        if (!m_valid && (ed || ei)) begin
            m_valid = 1;
            m_addr  = ed ? daddr : iaddr;
            m_cause = ed ? (dwr ? 2'b01 : 2'b00) : 2'b10;
        end
        m_count = m_count + int'(ed) + int'(ei);
        if (m_count > 255) m_count = 255;
        m_d = ed;
        m_i = ei;
        @(posedge clk);
        #1;
        chk("dmpu_deny",   32'(dmpu_deny),   32'(m_d));
        chk("impu_deny",   32'(impu_deny),   32'(m_i));
        chk("fault_valid", 32'(fault_valid), 32'(m_valid));
        chk("fault_addr",  fault_addr,       m_addr);
        chk("fault_cause", 32'(fault_cause), 32'(m_cause));
        chk("fault_count", 32'(fault_count), 32'(m_count));
    endtask

    task automatic idle_inputs();
        sup = 0; dreq = 0; dwr = 0; daddr = '0; ireq = 0; iaddr = '0; fclr = 0;
    endtask

    task automatic clear_regs();
        for (int i = 0; i < NR; i++) regs[i] = '0;
    endtask

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r3;
        logic        sup;
        logic        dreq;
        logic        dwr;
        logic [31:0] da;
        logic        ireq;
        logic [31:0] ia;
        logic        ed;
        logic        ei;
        string       name;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [63:0] sz;
        logic [63:0] start;
        logic [63:0] a64;
        int          r;

        tbl[0]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b1, 1'b0, 32'h000FFFFC, 1'b0, 32'h0, 1'b0, 1'b0, "ld_top_in"};
        tbl[1]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b1, 1'b0, 32'h00110000, 1'b0, 32'h0, 1'b1, 1'b0, "ld_outside"};
        tbl[2]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b1, 1'b1, 32'h00010000, 1'b0, 32'h0, 1'b1, 1'b0, "st_no_w"};
        tbl[3]  = '{32'h00010108, 32'h80000400, 1'b1, 1'b1, 1'b1, 32'h00010000, 1'b0, 32'h0, 1'b0, 1'b0, "st_super"};
        tbl[4]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000FFC, 1'b0, 1'b0, "fe_in"};
        tbl[5]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0, 1'b1, "fe_past"};
        tbl[6]  = '{32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, "both_zero"};
        tbl[7]  = '{32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h9ABC0000, 1'b0, 1'b0, "no_req"};
        tbl[8]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b1, 1'b0, 32'h00010000, 1'b0, 32'h0, 1'b0, 1'b0, "ld_base"};
        tbl[9]  = '{32'h00010108, 32'h80000400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00010000, 1'b0, 1'b1, "fe_no_x"};
        tbl[10] = '{32'h0000030F, 32'h0,        1'b0, 1'b1, 1'b1, 32'h07FFFFFC, 1'b0, 32'h0, 1'b0, 1'b0, "st_128m_in"};
        tbl[11] = '{32'h0000030F, 32'h0,        1'b0, 1'b1, 1'b1, 32'h08000000, 1'b0, 32'h0, 1'b1, 1'b0, "st_128m_out"};
        tbl[12] = '{32'h000FF108, 32'h80000400, 1'b0, 1'b1, 1'b0, 32'h00000010, 1'b1, 32'h80001000, 1'b0, 1'b1, "low_base_dc"};

        // Reset state
        rst_n = 0;
        idle_inputs();
        clear_regs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_dmpu_deny",   32'(dmpu_deny),   32'h0);
        chk("rst_fault_valid", 32'(fault_valid), 32'h0);
        chk("rst_fault_count", 32'(fault_count), 32'h0);
        cycle();

        // Directed table
        foreach (tbl[k]) begin
            clear_regs();
            regs[0] = tbl[k].r0;
            regs[3] = tbl[k].r3;
            sup = tbl[k].sup; dreq = tbl[k].dreq; dwr = tbl[k].dwr; daddr = tbl[k].da;
            ireq = tbl[k].ireq; iaddr = tbl[k].ia;
            cycle();
            chk({tbl[k].name, "_d"}, 32'(dmpu_deny), 32'(tbl[k].ed));
            chk({tbl[k].name, "_i"}, 32'(impu_deny), 32'(tbl[k].ei));
            idle_inputs();
            cycle();
            chk({tbl[k].name, "_d_drop"}, 32'(dmpu_deny), 32'h0);
        end

        // First capture after a clear
        idle_inputs();
        regs[0] = 32'h00010108;
        fclr = 1;
        cycle();
        fclr = 0;
        dreq = 1; daddr = 32'h00110000;
        cycle();
        chk("cap_addr",  fault_addr,              32'h00110000);
        chk("cap_cause", 32'(fault_cause),        32'h0);
        chk("cap_count", 32'(fault_count),        32'h1);
        // Supervisor store leaves the count unchanged
        sup = 1; dwr = 1; daddr = 32'h00010000;
        cycle();
        chk("sup_count", 32'(fault_count),        32'h1);
        chk("sup_deny",  32'(dmpu_deny),          32'h0);
        idle_inputs();

        // Simultaneous denies: data wins, count +2, later violation ignored
        clear_regs();
        fclr = 1;
        cycle();
        fclr = 0;
        dreq = 1; daddr = 32'h100; ireq = 1; iaddr = 32'h200;
        cycle();
        chk("dual_addr",  fault_addr,             32'h100);
        chk("dual_cause", 32'(fault_cause),       32'h0);
        chk("dual_count", 32'(fault_count),       32'h2);
        ireq = 0; daddr = 32'h300;
        cycle();
        chk("keep_addr",  fault_addr,             32'h100);
        chk("keep_count", 32'(fault_count),       32'h3);

        // Back-to-back pulses
        daddr = 32'h400;
        cycle();
        chk("b2b_deny",   32'(dmpu_deny),         32'h1);

        // Saturation
        for (int n = 0; n < 300; n++) cycle();
        chk("sat_count",  32'(fault_count),       32'hFF);
        // Clear coinciding with a denied fetch
        dreq = 0; ireq = 1; iaddr = 32'h0000_5000; fclr = 1;
        cycle();
        chk("clr_count",  32'(fault_count),       32'h1);
        chk("clr_valid",  32'(fault_valid),       32'h1);
        chk("clr_cause",  32'(fault_cause),       32'h2);
        chk("clr_addr",   fault_addr,             32'h0000_5000);
        fclr = 0;

        // Reset mid-sequence with a request in flight
        ireq = 0; dreq = 1; daddr = 32'h700;
        cycle();
        rst_n = 0;
        #1;
        chk("arst_dmpu",  32'(dmpu_deny),         32'h0);
        chk("arst_valid", 32'(fault_valid),       32'h0);
        chk("arst_addr",  fault_addr,             32'h0);
        chk("arst_count", 32'(fault_count),       32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_d", 32'(dmpu_deny),        32'h0);
        idle_inputs();
        rst_n = 1;
        model_reset();
        cycle();
        chk("post_rst_d", 32'(dmpu_deny),         32'h0);
        cycle();

        // Randomized traffic against the model
        for (int it = 0; it < 2000; it++) begin
            if (it % 64 == 0) begin
                for (int i = 0; i < NR; i++) regs[i] = $urandom;
            end
            sup  = ($urandom_range(0, 7) == 0);
            dreq = ($urandom_range(0, 3) != 0);
            ireq = ($urandom_range(0, 3) != 0);
            dwr  = 1'($urandom_range(0, 1));
            fclr = ($urandom_range(0, 31) == 0);
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    a64 = {32'h0, $urandom};
                end else begin
                    r     = $urandom_range(0, NR - 1);
                    sz    = 64'h1000 << regs[r][3:0];
                    start = {32'h0, regs[r][31:12], 12'h000} & ~(sz - 64'd1);
                    a64   = start + (64'($urandom) % (sz + 64'd8192)) - 64'd4096;
                end
                if (c == 0) daddr = {a64[31:2], 2'b00};
                else        iaddr = {a64[31:2], 2'b00};
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mpu_multi.md
# cpu_mpu_multi

Parametrised memory protection unit checking user-mode data and instruction-fetch accesses against up to 16 CSR-programmed regions. Sits beside the CPU load/store and fetch paths and returns a registered deny pulse one cycle after each request. Captures the first violation (address and cause) in sticky fault registers and keeps a saturating violation count for the trap handler.

## Interface
- NUM_REGIONS, 8, number of region descriptors checked (1..16)
- COUNT_WIDTH, 8, width of the saturating fault counter
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- supervisor  in  1  1 = supervisor mode (all accesses allowed), 0 = user mode
- cpud_request  in  1  data access request, one-cycle pulse
- cpud_write  in  1  1 = store, 0 = load
- cpud_addr  in  32  data access address
- cpui_request  in  1  instruction fetch request, one-cycle pulse
- cpui_addr  in  32  fetch address
- csr_mpu  in  NUM_REGIONS*32  region descriptors; region i at bits [32*i+31 : 32*i]
- fault_clear  in  1  clears fault_valid, fault_addr, fault_cause and fault_count
- dmpu_deny  out  1  data access denied, one cycle after cpud_request
- impu_deny  out  1  fetch denied, one cycle after cpui_request
- fault_valid  out  1  sticky: a violation has been captured
- fault_addr  out  32  address of the first captured violation
- fault_cause  out  2  00 = load, 01 = store, 10 = fetch, 11 unused
- fault_count  out  COUNT_WIDTH  number of violations since last clear, saturating

## Operation
- Descriptor fields: [31:12] base, [10] X, [9] W, [8] R, [3:0] log2 size (0 = 4 KB … 15 = 128 MB). Reserved bits [11], [7:4] are ignored.
- Size mask: mask[19:0] has ones above bit position min(size,15); a size code of 15 equals 128 MB, i.e. the low 15 bits are cleared.
- Hit: (addr[31:12] & mask) == (base & mask). Base bits below the mask are don't-care.
- Region permits a load if hit && R, a store if hit && W, a fetch if hit && X. A descriptor with R=W=X=0 is disabled.
- An access passes if any region permits it. Overlapping regions are OR-combined with no priority.
- Deny condition per channel: request && !supervisor && no region permits.
- Both channels are evaluated independently and concurrently every cycle.
- Fault capture when a deny is generated (registered edge):
  - If fault_valid=0, latch fault_addr and fault_cause and set fault_valid.
  - If fault_valid=1, keep the existing capture.
  - If both channels fault in the same cycle, the data channel is captured.
- fault_count adds the number of denies in that cycle (0, 1 or 2) and saturates at 2^COUNT_WIDTH-1.
- fault_clear has priority over accumulation:
  - A clear in a cycle with no new deny zeroes all fault state.
  - A clear coinciding with a new deny zeroes, then applies that deny: capture it, set fault_valid, and count = number of denies that cycle.

## Timing
- Requests, addresses, supervisor and csr_mpu are sampled on the clock edge ending the request cycle N.
- dmpu_deny and impu_deny are asserted throughout cycle N+1 and are single-cycle pulses. Back-to-back requests produce back-to-back independent pulses.
- Fault registers update on the same edge that raises the deny.
- A CSR write takes effect for requests sampled on or after the edge where csr_mpu changes. There is no internal shadowing.
- Reset (async assert, sync deassert by the system) forces all outputs to 0: dmpu_deny, impu_deny, fault_valid, fault_addr, fault_cause and fault_count. A deny pending for a request in the reset cycle is discarded.
- Without a request, the deny outputs are 0 regardless of address or permissions.

## Test plan
- Region0 = 0x0001_0108 (base 0x00010000, R, size 8 → 1 MB). User load at 0x000F_FFFC passes; user load at 0x0011_0000 gives dmpu_deny=1 at N+1, fault_addr=0x0011_0000, fault_cause=00, fault_count=1.
- Same region, user store at 0x0001_0000 is denied (W=0). Supervisor store to the same address gives dmpu_deny=0 and no count change.
- Region3 = 0x8000_0400 (X, 4 KB). Fetch at 0x8000_0FFC passes; fetch at 0x8000_1000 gives impu_deny=1 and fault_cause=10.
- With all regions zero, simultaneous user load 0x100 and fetch 0x200 give both denies. Capture is fault_addr=0x100, cause 00; count +2. A second violation leaves fault_addr unchanged.
- COUNT_WIDTH=8: 300 denied loads leave count at 255. fault_clear coinciding with a denied fetch leaves count=1, fault_valid=1, cause 10.
- Assert reset mid-sequence with fault_valid=1 and a request in flight: all outputs read 0 immediately and no deny appears after reset releases.
